mem_port_arbiter: RTL

- Shares one single-port main memory between instruction fetch (read-only) and the memory stage (load/store), replacing the fixed two-port split.
- Sequences each transaction: grant, issue, MEM_LATENCY-cycle wait, then read-data return. Raises a per-requester grant so fetch and memory stages stall on their own.
- Data requester has priority. A streak counter bounds fetch starvation. Fetch flush drops in-flight instruction reads on a squash.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_select.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter: owner and state codes,
// wait/streak counter width and a saturating increment helper.
package mem_port_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] OWNER_NONE  = 2'd0;
    localparam logic [1:0] OWNER_FETCH = 2'd1;
    localparam logic [1:0] OWNER_DATA  = 2'd2;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_WAIT = 1'b1;

    localparam cnt_t CNT_ZERO = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic cnt_t sat_inc(input cnt_t value, input cnt_t limit);
        cnt_t result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Winner selection for one grant slot: data has priority, but after MAX_STREAK
// consecutive data grants with fetch waiting, fetch takes the slot.
module arb_priority_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_elig,
    input  logic data_req,
    input  logic slot,
    output logic sel_fetch,
    output logic sel_data
);

    localparam cnt_t MAX_C = cnt_t'(MAX_STREAK);

    cnt_t streak_r;
    logic at_max_s;

    // Combinational winner for the current slot
    always_comb begin
        at_max_s  = (streak_r == MAX_C);
        sel_data  = slot & data_req & ~(fetch_elig & at_max_s);
        sel_fetch = slot & fetch_elig & ~(data_req & ~at_max_s);
    end

    // Streak only grows while fetch is actually being passed over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= CNT_ZERO;
        end else if (sel_data && fetch_elig) begin
            streak_r <= sat_inc(streak_r, MAX_C);
        end else if (sel_fetch || sel_data) begin
            streak_r <= CNT_ZERO;
        end else begin
            streak_r <= streak_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the memory stage:
// arbitrates a grant slot, issues the access and returns read data after MEM_LATENCY.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam cnt_t LAT_C = cnt_t'(MEM_LATENCY);

    logic [0:0]            state_r;
    cnt_t                  cnt_r;
    logic [1:0]            owner_r;
    logic                  flushed_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;

    logic last_s;
    logic slot_s;
    logic fetch_elig_s;
    logic sel_fetch_s;
    logic sel_data_s;
    logic issue_read_s;

    // Slot exists when idle or in the final wait cycle; never while in reset
    always_comb begin
        last_s       = (state_r == ARB_WAIT) && (cnt_r == LAT_C);
        slot_s       = ~rst & ((state_r == ARB_IDLE) | last_s);
        fetch_elig_s = fetch_req & ~fetch_flush;
    end

    arb_priority_select #(
        .MAX_STREAK(MAX_STREAK)
    ) u_select (
        .clk       (clk),
        .rst       (rst),
        .fetch_elig(fetch_elig_s),
        .data_req  (data_req),
        .slot      (slot_s),
        .sel_fetch (sel_fetch_s),
        .sel_data  (sel_data_s)
    );

    // Issue mux; address and write data hold their last value with no winner
    always_comb begin
        issue_read_s = sel_fetch_s | (sel_data_s & ~data_we);
        fetch_gnt    = sel_fetch_s;
        data_gnt     = sel_data_s;
        mem_ren      = issue_read_s;
        mem_wen      = sel_data_s & data_we;
        if (sel_fetch_s) begin
            mem_addr = fetch_addr;
        end else if (sel_data_s) begin
            mem_addr = data_addr;
        end else begin
            mem_addr = mem_addr_r;
        end
        if (sel_data_s) begin
            mem_wdata = data_wdata;
        end else begin
            mem_wdata = mem_wdata_r;
        end
    end

    // Return path: a flush in the return cycle suppresses the fetch pulse too
    always_comb begin
        fetch_rvalid = last_s & (owner_r == OWNER_FETCH) & ~flushed_r & ~fetch_flush;
        data_rvalid  = last_s & (owner_r == OWNER_DATA);
        busy         = (state_r == ARB_WAIT);
        if (fetch_rvalid) begin
            fetch_rdata = mem_rdata;
        end else begin
            fetch_rdata = {DATA_WIDTH{1'b0}};
        end
        if (data_rvalid) begin
            data_rdata = mem_rdata;
        end else begin
            data_rdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Read timing FSM; a new read issued in the final cycle restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ARB_IDLE;
            cnt_r     <= CNT_ZERO;
            owner_r   <= OWNER_NONE;
            flushed_r <= 1'b0;
        end else if (issue_read_s) begin
            state_r   <= ARB_WAIT;
            cnt_r     <= CNT_ONE;
            owner_r   <= sel_fetch_s ? OWNER_FETCH : OWNER_DATA;
            flushed_r <= 1'b0;
        end else if (last_s) begin
            state_r   <= ARB_IDLE;
            cnt_r     <= CNT_ZERO;
            owner_r   <= OWNER_NONE;
            flushed_r <= 1'b0;
        end else if (state_r == ARB_WAIT) begin
            state_r   <= state_r;
            cnt_r     <= cnt_r + CNT_ONE;
            owner_r   <= owner_r;
            flushed_r <= flushed_r | (fetch_flush & (owner_r == OWNER_FETCH));
        end else begin
            state_r   <= state_r;
            cnt_r     <= cnt_r;
            owner_r   <= owner_r;
            flushed_r <= flushed_r;
        end
    end

    // Hold registers for the idle-cycle memory address and write data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            mem_addr_r  <= mem_addr;
            mem_wdata_r <= mem_wdata;
        end
    end

endmodule
